// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types, default geometry and width helper for the matmul sequencer
package matmul_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_WB,
    S_DONE
  } state_t;

  localparam int DEF_N1    = 4;
  localparam int DEF_N2    = 4;
  localparam int DEF_M     = 8;
  localparam int TILES_R   = DEF_M / DEF_N1;
  localparam int TILES_C   = DEF_M / DEF_N2;
  localparam int DRAIN_LEN = DEF_N1 + DEF_N2 - 1;

  // Single-value counters still need a 1-bit register.
  function automatic int clog2_min1(input int x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction

endpackage

// File: rtl/matmul_sequencer_wrap_counter.sv
// rtl/matmul_sequencer_wrap_counter.sv - up-counter 0..MAX that wraps to 0 after MAX
module wrap_counter
  import matmul_pkg::*;
#(
  parameter int  MAX = 1,
  localparam int W   = clog2_min1(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         last
);

  assign last = (cnt == W'(MAX));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - tile scheduler for an N1xN2 systolic array computing an MxM product
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int  N1  = DEF_N1,
  parameter int  N2  = DEF_N2,
  parameter int  M   = DEF_M,
  localparam int KW  = $clog2(M),
  localparam int TRW = clog2_min1(M / N1),
  localparam int TCW = clog2_min1(M / N2),
  localparam int AW  = $clog2(M * M / N1),
  localparam int BW  = $clog2(M * M / N2),
  localparam int RW  = clog2_min1(N1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           wr_ready,
  output logic           busy,
  output logic           done,
  output logic           feed_valid,
  output logic           acc_clear,
  output logic [KW-1:0]  k_idx,
  output logic [TRW-1:0] tile_row,
  output logic [TCW-1:0] tile_col,
  output logic [AW-1:0]  rd_addr_A,
  output logic [BW-1:0]  rd_addr_B,
  output logic           wr_valid,
  output logic [RW-1:0]  wr_row,
  output logic [BW-1:0]  wr_addr
);

  localparam int DRAIN_MAX = N1 + N2 - 2;

  state_t state_q, state_d;

  logic in_idle;
  logic k_last, drain_last, row_last, col_last, trow_last;
  logic accept, tile_step;
  logic [clog2_min1(DRAIN_MAX + 1)-1:0] unused_drain_cnt;

  assign in_idle   = (state_q == S_IDLE);
  assign accept    = (state_q == S_WB) && wr_ready;
  assign tile_step = accept && row_last;

  wrap_counter #(.MAX(M - 1)) u_k (
    .clk(clk), .rst(rst), .clr(in_idle), .en(state_q == S_FEED),
    .cnt(k_idx), .last(k_last)
  );

  wrap_counter #(.MAX(DRAIN_MAX)) u_drain (
    .clk(clk), .rst(rst), .clr(in_idle), .en(state_q == S_DRAIN),
    .cnt(unused_drain_cnt), .last(drain_last)
  );

  wrap_counter #(.MAX(N1 - 1)) u_row (
    .clk(clk), .rst(rst), .clr(in_idle), .en(accept),
    .cnt(wr_row), .last(row_last)
  );

  // Column-inner tile walk: the row index only moves when the column wraps.
  wrap_counter #(.MAX(M / N2 - 1)) u_tcol (
    .clk(clk), .rst(rst), .clr(in_idle), .en(tile_step),
    .cnt(tile_col), .last(col_last)
  );

  wrap_counter #(.MAX(M / N1 - 1)) u_trow (
    .clk(clk), .rst(rst), .clr(in_idle), .en(tile_step && col_last),
    .cnt(tile_row), .last(trow_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    busy       = !in_idle;
    done       = 1'b0;
    feed_valid = 1'b0;
    acc_clear  = 1'b0;
    wr_valid   = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_FEED;
      S_FEED: begin
        feed_valid = 1'b1;
        acc_clear  = (k_idx == '0);
        if (k_last) state_d = S_DRAIN;
      end
      S_DRAIN: if (drain_last) state_d = S_WB;
      S_WB: begin
        wr_valid = 1'b1;
        if (tile_step) state_d = (col_last && trow_last) ? S_DONE : S_FEED;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All multipliers are powers of two, so these reduce to shifts and adds.
  assign rd_addr_A = AW'(32'(k_idx) + 32'(tile_row) * 32'(M));
  assign rd_addr_B = BW'(32'(k_idx) + 32'(tile_col) * 32'(M));
  assign wr_addr   = BW'((32'(tile_row) * 32'(N1) + 32'(wr_row)) * 32'(M / N2) + 32'(tile_col));

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb/tb_matmul_sequencer.sv - scoreboard bench for matmul_sequencer (M=8 and degenerate M=4)
module tb_matmul_sequencer;

  localparam int M  = 8;
  localparam int N1 = 4;
  localparam int N2 = 4;
  localparam int P  = M + (N1 + N2 - 1) + N1;
  localparam int T  = (M / N1) * (M / N2);

  logic clk = 1'b0;
  logic rst, start, wr_ready;
  logic busy, done, feed_valid, acc_clear, wr_valid;
  logic [2:0] k_idx;
  logic [0:0] tile_row, tile_col;
  logic [3:0] rd_addr_A, rd_addr_B, wr_addr;
  logic [1:0] wr_row;

  logic start4;
  logic wr_ready4 = 1'b1;
  logic busy4, done4, feed_valid4, acc_clear4, wr_valid4;
  logic [1:0] k_idx4, rd_addr_A4, rd_addr_B4, wr_row4, wr_addr4;
  logic [0:0] tile_row4, tile_col4;

  matmul_sequencer #(.N1(N1), .N2(N2), .M(M)) dut (
    .clk(clk), .rst(rst), .start(start), .wr_ready(wr_ready),
    .busy(busy), .done(done), .feed_valid(feed_valid), .acc_clear(acc_clear),
    .k_idx(k_idx), .tile_row(tile_row), .tile_col(tile_col),
    .rd_addr_A(rd_addr_A), .rd_addr_B(rd_addr_B),
    .wr_valid(wr_valid), .wr_row(wr_row), .wr_addr(wr_addr)
  );

  matmul_sequencer #(.N1(4), .N2(4), .M(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .wr_ready(wr_ready4),
    .busy(busy4), .done(done4), .feed_valid(feed_valid4), .acc_clear(acc_clear4),
    .k_idx(k_idx4), .tile_row(tile_row4), .tile_col(tile_col4),
    .rd_addr_A(rd_addr_A4), .rd_addr_B(rd_addr_B4),
    .wr_valid(wr_valid4), .wr_row(wr_row4), .wr_addr(wr_addr4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [13:0] feed_q[$];
  logic [7:0]  wr_q[$];
  int          done_q[$];
  int          clr_q[$];
  int  base = 0;
  bit  timing = 0;
  bit  run4 = 0;
  int  f4, w4, d4;

  // Reference schedule: every operand read and every result row of one full multiply, in order.
  task automatic push_run(input int stall);
    for (int tr = 0; tr < M / N1; tr++) begin
      for (int tc = 0; tc < M / N2; tc++) begin
        int t;
        t = tr * (M / N2) + tc;
        if (timing) clr_q.push_back(1 + t * P + ((t > 0) ? stall : 0));
        for (int k = 0; k < M; k++)
          feed_q.push_back({k == 0, 3'(k), 1'(tr), 1'(tc), 4'(k + tr * M), 4'(k + tc * M)});
        for (int r = 0; r < N1; r++)
          wr_q.push_back({1'(tr), 1'(tc), 2'(r), 4'((tr * N1 + r) * (M / N2) + tc)});
      end
    end
    done_q.push_back(timing ? (1 + T * P + stall) : -1);
  endtask

  int          rel, e;
  bit          chk_busy = 0, chk_busy4 = 0, prev_stall = 0;
  logic [5:0]  prev_wr;

  always @(negedge clk) begin
    rel = cyc - base + 1;
    if (chk_busy) begin
      check("busy_after_done", 32'(busy), 0);
      chk_busy = 0;
    end
    if (feed_valid === 1'b1) begin
      if (feed_q.size() == 0) check("feed_unexpected", 1, 0);
      else check("feed_beat", {acc_clear, k_idx, tile_row, tile_col, rd_addr_A, rd_addr_B},
                 32'(feed_q.pop_front()));
    end
    if (acc_clear === 1'b1 && timing) begin
      if (clr_q.size() == 0) check("acc_clear_unexpected", 1, 0);
      else check("acc_clear_cycle", rel, clr_q.pop_front());
    end
    if (wr_valid === 1'b1 && prev_stall) check("stall_hold", {wr_row, wr_addr}, prev_wr);
    prev_stall = (wr_valid === 1'b1) && !wr_ready;
    prev_wr    = {wr_row, wr_addr};
    if (wr_valid === 1'b1 && wr_ready) begin
      if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
      else check("wr_row_addr", {tile_row, tile_col, wr_row, wr_addr}, 32'(wr_q.pop_front()));
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) check("done_unexpected", 1, 0);
      else begin
        e = done_q.pop_front();
        if (e >= 0) check("done_cycle", rel, e);
        check("done_all_rows", feed_q.size() + wr_q.size(), 0);
        chk_busy = 1;
      end
    end
    if (chk_busy4) begin
      check("busy4_after_done", 32'(busy4), 0);
      chk_busy4 = 0;
    end
    if (run4) begin
      if (feed_valid4 === 1'b1) begin
        check("feed4_beat", {acc_clear4, tile_row4, tile_col4, rd_addr_A4, rd_addr_B4},
              {f4 == 0, 1'b0, 1'b0, 2'(f4), 2'(f4)});
        f4++;
      end
      if (wr_valid4 === 1'b1) begin
        check("wr4_addr", {wr_row4, wr_addr4}, {2'(w4), 2'(w4)});
        w4++;
      end
      if (done4 === 1'b1) begin
        check("done4_cycle", rel, 16);
        d4++;
        chk_busy4 = 1;
      end
    end
  end

  // mode 0 baseline, 1 write-back stall, 2 start pulse while busy, 3 random ready/start
  task automatic run(input int mode);
    bit fin;
    @(posedge clk); #1;
    timing = (mode < 3);
    push_run((mode == 1) ? 5 : 0);
    start = 1'b1;
    wr_ready = 1'b1;
    base = cyc + 1;
    if (mode == 0) begin
      run4 = 1; start4 = 1'b1; f4 = 0; w4 = 0; d4 = 0;
    end
    fin = 0;
    for (int n = 1; n <= 3000; n++) begin
      @(posedge clk); #1;
      start4 = 1'b0;
      start = ((mode == 2) && (n == 30)) ||
              ((mode == 3) && busy && ($urandom_range(0, 7) == 0));
      case (mode)
        1:       wr_ready = !(n >= 18 && n <= 22);
        3:       wr_ready = ($urandom_range(0, 3) != 0);
        default: wr_ready = 1'b1;
      endcase
      if (!busy && n > 2) begin
        fin = 1;
        break;
      end
    end
    start = 1'b0;
    wr_ready = 1'b1;
    if (!fin) check("run_timeout", 0, 1);
    @(negedge clk);
    check("queues_drained", feed_q.size() + wr_q.size() + done_q.size() + clr_q.size(), 0);
    if (mode == 0) begin
      check("dut4_counts", {8'(f4), 8'(w4), 8'(d4)}, {8'd4, 8'd4, 8'd1});
      run4 = 0;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start4 = 1'b0; wr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", {busy, done, feed_valid, acc_clear, wr_valid, k_idx, tile_row,
                            tile_col, wr_row, rd_addr_A, rd_addr_B, wr_addr}, 0);

    run(0);
    run(1);
    run(2);

    // Reset asserted mid-FEED.
    @(posedge clk); #1;
    timing = 0;
    push_run(0);
    start = 1'b1;
    base = cyc + 1;
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    feed_q.delete(); wr_q.delete(); done_q.delete(); clr_q.delete();
    @(negedge clk);
    check("reset_mid_feed", {busy, done, feed_valid, acc_clear, wr_valid, k_idx, tile_row,
                             tile_col, wr_row, rd_addr_A, rd_addr_B, wr_addr}, 0);
    repeat (20) @(negedge clk);

    for (int i = 0; i < 4; i++) run(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
